// File: rtl/t02_ram_responder.sv
// Word-addressed RAM responder for the core's request bus: accepts one read or
// write in IDLE, stalls LATENCY cycles in BUSY, and reports completion in DONE.
module t02_ram_responder #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned LATENCY     = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] ramaddr,
  input  logic [31:0] ramstore,
  input  logic        Ren,
  input  logic        Wen,
  output logic [31:0] ramload,
  output logic        busy_o,
  output logic        err_o
);

  localparam int unsigned AW       = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0]  LAT      = 4'(LATENCY);
  localparam logic [31:0] BAD_WORD = 32'hBAD0_BAD0;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic        op_wr;
  logic [AW-1:0] idx;
  logic [31:0] data;
  logic        range_err;

  logic [31:0] mem [DEPTH_WORDS];

  logic [31:0] word_off;
  logic        req_in_range;
  logic        access;

  // Range is judged on the full word offset, so only the in-range index is stored.
  assign word_off     = (ramaddr - BASE_ADDR) >> 2;
  assign req_in_range = (ramaddr >= BASE_ADDR) && (word_off < 32'(DEPTH_WORDS));
  assign access       = (state == BUSY) && (cnt == 4'd1);

  assign busy_o = (state == BUSY) || ((state == IDLE) && (Ren || Wen));

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      op_wr     <= 1'b0;
      idx       <= '0;
      data      <= '0;
      range_err <= 1'b0;
      ramload   <= '0;
      err_o     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          err_o <= 1'b0;
          if (Wen || Ren) begin
            op_wr     <= Wen;
            idx       <= word_off[AW-1:0];
            data      <= ramstore;
            range_err <= ~req_in_range;
            cnt       <= LAT;
            state     <= BUSY;
          end
        end
        BUSY: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            if (!op_wr) begin
              ramload <= range_err ? BAD_WORD : mem[idx];
            end
            err_o <= range_err;
            state <= DONE;
          end
        end
        DONE: begin
          err_o <= 1'b0;
          state <= IDLE;
        end
        default: begin
          err_o <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  // Array has no reset; a reset landing on the access cycle abandons the write.
  always_ff @(posedge clk) begin
    if (!rst && access && op_wr && !range_err) begin
      mem[idx] <= data;
    end
  end

endmodule

// File: tb/tb_t02_ram_responder.sv
// Self-checking bench for t02_ram_responder: table-driven transactions on the
// LATENCY=2 instance, plus held-request and reset-mid-op sequences on 1/2/15.
module tb_t02_ram_responder;

  logic        clk;
  logic        rst;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic        Ren;
  logic        Wen;

  logic [31:0] load1, load2, load15;
  logic        busy1, busy2, busy15;
  logic        err1, err2, err15;

  int checks;
  int failures;

  typedef struct {
    logic        wen;
    logic        ren;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_load;
    logic        exp_err;
  } vec_t;

  typedef struct {
    logic [31:0] load;
    logic        err;
  } exp_t;

  vec_t vecs[12];
  exp_t sb[$];

  t02_ram_responder #(.DEPTH_WORDS(256), .LATENCY(1), .BASE_ADDR(32'h0)) dut_l1 (
    .clk(clk), .rst(rst), .ramaddr(ramaddr), .ramstore(ramstore), .Ren(Ren), .Wen(Wen),
    .ramload(load1), .busy_o(busy1), .err_o(err1)
  );

  t02_ram_responder #(.DEPTH_WORDS(256), .LATENCY(2), .BASE_ADDR(32'h0)) dut_l2 (
    .clk(clk), .rst(rst), .ramaddr(ramaddr), .ramstore(ramstore), .Ren(Ren), .Wen(Wen),
    .ramload(load2), .busy_o(busy2), .err_o(err2)
  );

  t02_ram_responder #(.DEPTH_WORDS(256), .LATENCY(15), .BASE_ADDR(32'h0)) dut_l15 (
    .clk(clk), .rst(rst), .ramaddr(ramaddr), .ramstore(ramstore), .Ren(Ren), .Wen(Wen),
    .ramload(load15), .busy_o(busy15), .err_o(err15)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check32(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  // One transaction on the LATENCY=2 instance, with inputs scrambled after accept.
  task automatic do_txn(input int i);
    int   nbusy;
    bit   seen_done;
    exp_t e;
    @(negedge clk);
    Wen      = vecs[i].wen;
    Ren      = vecs[i].ren;
    ramaddr  = vecs[i].addr;
    ramstore = vecs[i].wdata;
    #1;
    check32($sformatf("v%0d_busy_accept", i), {31'b0, busy2}, 32'd1);
    sb.push_back('{load: vecs[i].exp_load, err: vecs[i].exp_err});
    nbusy     = 1;
    seen_done = 1'b0;
    for (int k = 0; k < 40 && !seen_done; k++) begin
      @(negedge clk);
      if (k == 0) begin
        Wen      = 1'b0;
        Ren      = 1'b0;
        ramaddr  = ~vecs[i].addr;
        ramstore = ~vecs[i].wdata;
      end
      #1;
      if (busy2) nbusy++;
      else seen_done = 1'b1;
    end
    if (!seen_done) begin
      checks++;
      failures++;
      $display("FAIL v%0d_timeout actual=busy required=done", i);
    end else if (sb.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL v%0d_scoreboard actual=empty required=entry", i);
    end else begin
      e = sb.pop_front();
      check32($sformatf("v%0d_busy_len", i), 32'(nbusy), 32'd3);
      check32($sformatf("v%0d_load", i), load2, e.load);
      check32($sformatf("v%0d_err", i), {31'b0, err2}, {31'b0, e.err});
      @(negedge clk);
      #1;
      check32($sformatf("v%0d_err_after", i), {31'b0, err2}, 32'd0);
      check32($sformatf("v%0d_idle_busy", i), {31'b0, busy2}, 32'd0);
    end
  endtask

  // Single-cycle request seen by all three instances; counts busy cycles over 20 cycles.
  task automatic pulse_all(input logic we, input logic re, input logic [31:0] addr,
                           input logic [31:0] wd, output int n1, output int n2, output int n15);
    n1 = 0;
    n2 = 0;
    n15 = 0;
    @(negedge clk);
    Wen      = we;
    Ren      = re;
    ramaddr  = addr;
    ramstore = wd;
    for (int c = 0; c < 20; c++) begin
      if (c > 0) begin
        @(negedge clk);
        if (c == 1) begin
          Wen = 1'b0;
          Ren = 1'b0;
        end
      end
      #1;
      n1  += int'(busy1);
      n2  += int'(busy2);
      n15 += int'(busy15);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    Wen = 1'b0;
    Ren = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int   n1, n2, n15;
    exp_t e;
    checks   = 0;
    failures = 0;

    vecs[0]  = '{1'b1, 1'b0, 32'h0000_0000, 32'h0000_0001, 32'h0000_0000, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0};
    vecs[2]  = '{1'b0, 1'b1, 32'h0000_0010, 32'h0000_0000, 32'hDEAD_BEEF, 1'b0};
    vecs[3]  = '{1'b1, 1'b1, 32'h0000_0020, 32'h1234_5678, 32'hDEAD_BEEF, 1'b0};
    vecs[4]  = '{1'b0, 1'b1, 32'h0000_0020, 32'h0000_0000, 32'h1234_5678, 1'b0};
    vecs[5]  = '{1'b0, 1'b1, 32'h0000_0400, 32'h0000_0000, 32'hBAD0_BAD0, 1'b1};
    vecs[6]  = '{1'b1, 1'b0, 32'h0000_0400, 32'hFFFF_FFFF, 32'hBAD0_BAD0, 1'b1};
    vecs[7]  = '{1'b0, 1'b1, 32'h0000_0000, 32'h0000_0000, 32'h0000_0001, 1'b0};
    vecs[8]  = '{1'b1, 1'b0, 32'h0000_03FC, 32'hA5A5_5A5A, 32'h0000_0001, 1'b0};
    vecs[9]  = '{1'b0, 1'b1, 32'h0000_03FC, 32'h0000_0000, 32'hA5A5_5A5A, 1'b0};
    vecs[10] = '{1'b0, 1'b1, 32'h0000_0013, 32'h0000_0000, 32'hDEAD_BEEF, 1'b0};
    vecs[11] = '{1'b0, 1'b1, 32'hFFFF_FFFC, 32'h0000_0000, 32'hBAD0_BAD0, 1'b1};

    rst      = 1'b1;
    Ren      = 1'b1;
    Wen      = 1'b0;
    ramaddr  = 32'h10;
    ramstore = 32'h0;

    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      #1;
      check32("rst_load", load2, 32'h0);
      check32("rst_err", {31'b0, err2}, 32'd0);
      check32("rst_busy_ren", {31'b0, busy2}, 32'd1);
    end
    @(negedge clk);
    rst = 1'b0;
    Ren = 1'b0;
    #1;
    check32("rst_release_busy", {31'b0, busy2}, 32'd0);
    check32("rst_release_load", load2, 32'h0);

    for (int i = 0; i < 12; i++) do_txn(i);

    // Held read: accepts at i=0,4,8 must latch 0x10 even though ramaddr wanders.
    do_reset();
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      Ren      = 1'b1;
      Wen      = 1'b0;
      ramaddr  = (i % 4 == 0) ? 32'h10 : 32'h20;
      ramstore = $urandom;
      #1;
      if (i % 4 == 0) sb.push_back('{load: 32'hDEAD_BEEF, err: 1'b0});
      if (i % 4 == 3) begin
        check32($sformatf("held_busy_low_%0d", i), {31'b0, busy2}, 32'd0);
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL held_scoreboard_%0d actual=empty required=entry", i);
        end else begin
          e = sb.pop_front();
          check32($sformatf("held_load_%0d", i), load2, e.load);
        end
      end else begin
        check32($sformatf("held_busy_high_%0d", i), {31'b0, busy2}, 32'd1);
      end
    end
    Ren = 1'b0;

    do_reset();
    pulse_all(1'b1, 1'b0, 32'h30, 32'h0BAD_F00D, n1, n2, n15);
    pulse_all(1'b0, 1'b1, 32'h30, 32'h0, n1, n2, n15);
    check32("len_l1", 32'(n1), 32'd2);
    check32("len_l2", 32'(n2), 32'd3);
    check32("len_l15", 32'(n15), 32'd16);
    check32("pre_load_l1", load1, 32'h0BAD_F00D);
    check32("pre_load_l2", load2, 32'h0BAD_F00D);
    check32("pre_load_l15", load15, 32'h0BAD_F00D);

    // Reset lands in the cycle after accept; for LATENCY=1 that is the access cycle.
    @(negedge clk);
    Wen      = 1'b1;
    ramaddr  = 32'h30;
    ramstore = 32'hCAFE_0000;
    #1;
    check32("mid_accept_l1", {31'b0, busy1}, 32'd1);
    check32("mid_accept_l15", {31'b0, busy15}, 32'd1);
    @(negedge clk);
    Wen = 1'b0;
    rst = 1'b1;
    #1;
    check32("mid_busy_l1", {31'b0, busy1}, 32'd1);
    check32("mid_busy_l2", {31'b0, busy2}, 32'd1);
    check32("mid_busy_l15", {31'b0, busy15}, 32'd1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check32("mid_idle_l1", {31'b0, busy1}, 32'd0);
    check32("mid_idle_l2", {31'b0, busy2}, 32'd0);
    check32("mid_idle_l15", {31'b0, busy15}, 32'd0);
    check32("mid_load_l1", load1, 32'h0);
    check32("mid_load_l2", load2, 32'h0);
    check32("mid_load_l15", load15, 32'h0);

    pulse_all(1'b0, 1'b1, 32'h30, 32'h0, n1, n2, n15);
    check32("post_load_l1", load1, 32'h0BAD_F00D);
    check32("post_load_l2", load2, 32'h0BAD_F00D);
    check32("post_load_l15", load15, 32'h0BAD_F00D);
    check32("post_len_l15", 32'(n15), 32'd16);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
